// File: rtl/tinyqv_data_arbiter.sv
// tinyqv_data_arbiter
// Shares the single downstream data memory port between the tinyQV CPU data
// interface and a secondary DMA/debug master. The winning request is registered
// onto mem_*, completions are routed back to the granted master, and bursts
// flagged with continue stay atomic for the master that opened them.
// Optional feature macro: DATA_ARB_FAIRNESS_EN adds a starvation counter that
// forces a waiting DMA through after STARVE_LIMIT contended CPU wins.
module tinyqv_data_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rstn_i,

  input  logic [27:0] cpu_addr_i,
  input  logic [1:0]  cpu_write_n_i,
  input  logic [1:0]  cpu_read_n_i,
  input  logic [31:0] cpu_data_out_i,
  input  logic        cpu_continue_i,
  output logic        cpu_ready_o,

  input  logic [27:0] dma_addr_i,
  input  logic [1:0]  dma_write_n_i,
  input  logic [1:0]  dma_read_n_i,
  input  logic [31:0] dma_data_out_i,
  input  logic        dma_continue_i,
  output logic        dma_ready_o,

  output logic [31:0] rd_data_o,

  output logic [27:0] mem_addr_o,
  output logic [1:0]  mem_write_n_o,
  output logic [1:0]  mem_read_n_o,
  output logic [31:0] mem_data_out_o,
  output logic        mem_continue_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_in_i
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_CPU,
    BUSY_DMA,
    LOCK_CPU,
    LOCK_DMA
  } state_e;

  state_e      state_q, state_d;
  logic [27:0] memAddr_q, memAddr_d;
  logic [1:0]  memWrite_q, memWrite_d;
  logic [1:0]  memRead_q, memRead_d;
  logic [31:0] memData_q, memData_d;
  logic        memCont_q, memCont_d;

  logic cpuReq;
  logic dmaReq;
  logic pickDma;
  logic loadCpu;
  logic loadDma;

  assign cpuReq = (cpu_read_n_i != 2'b11) || (cpu_write_n_i != 2'b11);
  assign dmaReq = (dma_read_n_i != 2'b11) || (dma_write_n_i != 2'b11);

`ifdef DATA_ARB_FAIRNESS_EN
  localparam int CNT_W = (STARVE_LIMIT < 3) ? 2 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
  logic             starved;

  assign starved = (starveCnt_q >= CNT_W'(STARVE_LIMIT));

  // IDLE arbitration: the CPU wins contention unless the DMA has been starved
  always_comb begin
    pickDma = 1'b0;
    if (dmaReq && (!cpuReq || starved)) begin
      pickDma = 1'b1;
    end
  end

  // Count CPU wins over a waiting DMA; any DMA grant clears the history
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (loadDma) begin
      starveCnt_d = '0;
    end else if ((state_q == IDLE) && loadCpu && dmaReq &&
                 (starveCnt_q < CNT_W'(STARVE_LIMIT))) begin
      starveCnt_d = starveCnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  localparam int unusedStarveLimit = STARVE_LIMIT;

  // IDLE arbitration: fixed priority, the CPU always wins contention
  always_comb begin
    pickDma = 1'b0;
    if (dmaReq && !cpuReq) begin
      pickDma = 1'b1;
    end
  end
`endif

  // Next-state and downstream request logic; a load copies the master's fields
  always_comb begin
    state_d    = state_q;
    memAddr_d  = memAddr_q;
    memWrite_d = memWrite_q;
    memRead_d  = memRead_q;
    memData_d  = memData_q;
    memCont_d  = memCont_q;
    loadCpu    = 1'b0;
    loadDma    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickDma) begin
          loadDma = 1'b1;
          state_d = BUSY_DMA;
        end else if (cpuReq) begin
          loadCpu = 1'b1;
          state_d = BUSY_CPU;
        end
      end
      BUSY_CPU: begin
        memCont_d = cpu_continue_i;
        if (mem_ready_i) begin
          memRead_d  = 2'b11;
          memWrite_d = 2'b11;
          state_d    = cpu_continue_i ? LOCK_CPU : IDLE;
        end
      end
      BUSY_DMA: begin
        memCont_d = dma_continue_i;
        if (mem_ready_i) begin
          memRead_d  = 2'b11;
          memWrite_d = 2'b11;
          state_d    = dma_continue_i ? LOCK_DMA : IDLE;
        end
      end
      LOCK_CPU: begin
        if (cpuReq) begin
          loadCpu = 1'b1;
          state_d = BUSY_CPU;
        end else if (!cpu_continue_i) begin
          memCont_d = 1'b0;
          state_d   = IDLE;
        end
      end
      LOCK_DMA: begin
        if (dmaReq) begin
          loadDma = 1'b1;
          state_d = BUSY_DMA;
        end else if (!dma_continue_i) begin
          memCont_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (loadCpu) begin
      memAddr_d  = cpu_addr_i;
      memWrite_d = cpu_write_n_i;
      memRead_d  = cpu_read_n_i;
      memData_d  = cpu_data_out_i;
      memCont_d  = cpu_continue_i;
    end else if (loadDma) begin
      memAddr_d  = dma_addr_i;
      memWrite_d = dma_write_n_i;
      memRead_d  = dma_read_n_i;
      memData_d  = dma_data_out_i;
      memCont_d  = dma_continue_i;
    end
  end

  // State and registered downstream request, with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      memAddr_q  <= '0;
      memWrite_q <= 2'b11;
      memRead_q  <= 2'b11;
      memData_q  <= '0;
      memCont_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      memAddr_q  <= memAddr_d;
      memWrite_q <= memWrite_d;
      memRead_q  <= memRead_d;
      memData_q  <= memData_d;
      memCont_q  <= memCont_d;
    end
  end

  // Completion goes only to the master that owns the issued transaction;
  // a cycle with reset asserted never delivers a completion
  assign cpu_ready_o = rstn_i && mem_ready_i && (state_q == BUSY_CPU);
  assign dma_ready_o = rstn_i && mem_ready_i && (state_q == BUSY_DMA);

  assign rd_data_o      = mem_data_in_i;
  assign mem_addr_o     = memAddr_q;
  assign mem_write_n_o  = memWrite_q;
  assign mem_read_n_o   = memRead_q;
  assign mem_data_out_o = memData_q;
  assign mem_continue_o = memCont_q;

endmodule

// File: tb/tb_tinyqv_data_arbiter.sv
// tb_tinyqv_data_arbiter
// Drives both masters and plays the memory side; grant decisions come from a
// small arbitration model kept below (fixed CPU priority, or the starvation
// rule when DATA_ARB_FAIRNESS_EN is defined).
module tb_tinyqv_data_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [27:0] cpuAddr;
  logic [1:0]  cpuWriteN, cpuReadN;
  logic [31:0] cpuDataOut;
  logic        cpuContinue, cpuReady;
  logic [27:0] dmaAddr;
  logic [1:0]  dmaWriteN, dmaReadN;
  logic [31:0] dmaDataOut;
  logic        dmaContinue, dmaReady;
  logic [31:0] rdData;
  logic [27:0] memAddr;
  logic [1:0]  memWriteN, memReadN;
  logic [31:0] memDataOut;
  logic        memContinue, memReady;
  logic [31:0] memDataIn;

  int checks = 0;
  int failures = 0;
  int starveCnt = 0;

  // Free-running clock
  always #5 clk = ~clk;

  tinyqv_data_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .cpu_addr_i     (cpuAddr),
    .cpu_write_n_i  (cpuWriteN),
    .cpu_read_n_i   (cpuReadN),
    .cpu_data_out_i (cpuDataOut),
    .cpu_continue_i (cpuContinue),
    .cpu_ready_o    (cpuReady),
    .dma_addr_i     (dmaAddr),
    .dma_write_n_i  (dmaWriteN),
    .dma_read_n_i   (dmaReadN),
    .dma_data_out_i (dmaDataOut),
    .dma_continue_i (dmaContinue),
    .dma_ready_o    (dmaReady),
    .rd_data_o      (rdData),
    .mem_addr_o     (memAddr),
    .mem_write_n_o  (memWriteN),
    .mem_read_n_o   (memReadN),
    .mem_data_out_o (memDataOut),
    .mem_continue_o (memContinue),
    .mem_ready_i    (memReady),
    .mem_data_in_i  (memDataIn)
  );

  // Arbitration model: returns 1 when the DMA should win this grant
  function automatic bit modelGrant(input bit cpuWants, input bit dmaWants);
    bit dmaWins;
`ifdef DATA_ARB_FAIRNESS_EN
    dmaWins = dmaWants && (!cpuWants || (starveCnt >= LIMIT));
`else
    dmaWins = dmaWants && !cpuWants;
`endif
    if (dmaWins) starveCnt = 0;
    else if (cpuWants && dmaWants && (starveCnt < LIMIT)) starveCnt = starveCnt + 1;
    return dmaWins;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCpu(input logic [27:0] a, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] d, input logic c);
    cpuAddr = a; cpuReadN = rd; cpuWriteN = wr; cpuDataOut = d; cpuContinue = c;
  endtask

  task automatic setDma(input logic [27:0] a, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] d, input logic c);
    dmaAddr = a; dmaReadN = rd; dmaWriteN = wr; dmaDataOut = d; dmaContinue = c;
  endtask

  task automatic randOp(output logic [1:0] rd, output logic [1:0] wr);
    logic [1:0] size;
    size = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) begin
      rd = size; wr = 2'b11;
    end else begin
      rd = 2'b11; wr = size;
    end
  endtask

  task automatic localReset();
    rstn = 1'b0;
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    setDma('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b0;
    tick();
    rstn = 1'b1;
    starveCnt = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    setDma('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b1;
    memDataIn = 32'h1234_5678;
    tick();
    tick();
    starveCnt = 0;
    checks++;
    if ({memReadN, memWriteN, memContinue} !== 5'b11110) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", {memReadN, memWriteN, memContinue}, 5'b11110);
    end
    checks++;
    if ({memAddr, memDataOut} !== 60'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 0", {memAddr, memDataOut});
    end
    checks++;
    if ({cpuReady, dmaReady} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b expected 00", {cpuReady, dmaReady});
    end
    checks++;
    if (rdData !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL rd_data_pass: got %h expected 12345678", rdData);
    end
    rstn = 1'b1;
    memReady = 1'b0;
    tick();
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_ignores_ready: got %b expected 00", {cpuReady, dmaReady});
    end
    memReady = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    int pulses;
    setCpu(28'h0000100, 2'b10, 2'b11, 32'h0, 1'b0);
    void'(modelGrant(1'b1, 1'b0));
    tick();
    checks++;
    if ({memAddr, memReadN, memWriteN} !== {28'h0000100, 2'b10, 2'b11}) begin
      failures++;
      $display("[TB] FAIL cpu_read_issue: got %h/%b/%b expected 0000100/10/11", memAddr, memReadN, memWriteN);
    end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (cpuReady || dmaReady) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("[TB] FAIL cpu_read_early_ready: got %0d pulses expected 0", pulses);
    end
    memDataIn = 32'hDEADBEEF;
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady, rdData} !== {2'b10, 32'hDEADBEEF}) begin
      failures++;
      $display("[TB] FAIL cpu_read_done: got %b %b %h expected 1 0 deadbeef", cpuReady, dmaReady, rdData);
    end
    tick();
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b0;
    #1;
    checks++;
    if ({memReadN, cpuReady} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL cpu_read_release: got %b/%b expected 11/0", memReadN, cpuReady);
    end
    tick();
  endtask

  task automatic test_dma_write();
    setDma(28'h0000020, 2'b11, 2'b00, 32'h000000A5, 1'b0);
    void'(modelGrant(1'b0, 1'b1));
    tick();
    checks++;
    if ({memAddr, memWriteN, memReadN, memDataOut} !== {28'h0000020, 2'b00, 2'b11, 32'h000000A5}) begin
      failures++;
      $display("[TB] FAIL dma_write_issue: got %h/%b/%b/%h expected 0000020/00/11/000000a5",
               memAddr, memWriteN, memReadN, memDataOut);
    end
    tick();
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL dma_write_done: got %b expected 01", {cpuReady, dmaReady});
    end
    tick();
    setDma('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b0;
    #1;
    checks++;
    if (memWriteN !== 2'b11) begin
      failures++;
      $display("[TB] FAIL dma_write_release: got %b expected 11", memWriteN);
    end
    tick();
  endtask

  task automatic test_random_single();
    bit          useDma;
    logic [27:0] a;
    logic [31:0] d, r;
    logic [1:0]  rd, wr;
    int          lat, pulses;
    for (int i = 0; i < 16; i++) begin
      useDma = 1'($urandom_range(0, 1));
      a = 28'($urandom);
      d = $urandom;
      r = $urandom;
      lat = $urandom_range(0, 3);
      randOp(rd, wr);
      if (useDma) setDma(a, rd, wr, d, 1'b0);
      else        setCpu(a, rd, wr, d, 1'b0);
      void'(modelGrant(!useDma, useDma));
      tick();
      checks++;
      if ({memAddr, memReadN, memWriteN, memDataOut, memContinue} !== {a, rd, wr, d, 1'b0}) begin
        failures++;
        $display("[TB] FAIL rand_issue: got %h/%b/%b/%h expected %h/%b/%b/%h",
                 memAddr, memReadN, memWriteN, memDataOut, a, rd, wr, d);
      end
      pulses = 0;
      for (int k = 0; k < lat; k++) begin
        if (cpuReady || dmaReady) pulses++;
        tick();
      end
      memDataIn = r;
      memReady = 1'b1;
      #1;
      checks++;
      if ({pulses[3:0], cpuReady, dmaReady, rdData} !== {4'd0, !useDma, useDma, r}) begin
        failures++;
        $display("[TB] FAIL rand_ready: got early=%0d rdy=%b%b data=%h expected early=0 rdy=%b%b data=%h",
                 pulses, cpuReady, dmaReady, rdData, !useDma, useDma, r);
      end
      checks++;
      if ({memAddr, memReadN, memWriteN} !== {a, rd, wr}) begin
        failures++;
        $display("[TB] FAIL rand_hold: got %h/%b/%b expected %h/%b/%b", memAddr, memReadN, memWriteN, a, rd, wr);
      end
      tick();
      setCpu('0, 2'b11, 2'b11, '0, 1'b0);
      setDma('0, 2'b11, 2'b11, '0, 1'b0);
      memReady = 1'b0;
      #1;
      checks++;
      if ({memReadN, memWriteN} !== 4'hF) begin
        failures++;
        $display("[TB] FAIL rand_release: got %b expected 1111", {memReadN, memWriteN});
      end
      tick();
    end
  endtask

  task automatic test_contention();
    bit          dmaWins;
    logic [27:0] ca, da;
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      ca = {1'b0, 27'($urandom)};
      da = {1'b1, 27'($urandom)};
      setCpu(ca, 2'b10, 2'b11, '0, 1'b0);
      setDma(da, 2'b11, 2'b10, $urandom, 1'b0);
      dmaWins = modelGrant(1'b1, 1'b1);
      tick();
      checks++;
      if (memAddr !== (dmaWins ? da : ca)) begin
        failures++;
        $display("[TB] FAIL contend_winner: got %h expected %h", memAddr, dmaWins ? da : ca);
      end
      lat = $urandom_range(0, 2);
      for (int k = 0; k < lat; k++) tick();
      r = $urandom;
      memDataIn = r;
      memReady = 1'b1;
      #1;
      checks++;
      if ({cpuReady, dmaReady, rdData} !== {!dmaWins, dmaWins, r}) begin
        failures++;
        $display("[TB] FAIL contend_win_ready: got %b%b %h expected %b%b %h",
                 cpuReady, dmaReady, rdData, !dmaWins, dmaWins, r);
      end
      tick();
      if (dmaWins) setDma('0, 2'b11, 2'b11, '0, 1'b0);
      else         setCpu('0, 2'b11, 2'b11, '0, 1'b0);
      #1;
      checks++;
      if ({cpuReady, dmaReady, memReadN, memWriteN} !== 6'b001111) begin
        failures++;
        $display("[TB] FAIL contend_idle_gap: got %b expected 001111", {cpuReady, dmaReady, memReadN, memWriteN});
      end
      memReady = 1'b0;
      void'(modelGrant(dmaWins, !dmaWins));
      tick();
      checks++;
      if (memAddr !== (dmaWins ? ca : da)) begin
        failures++;
        $display("[TB] FAIL contend_loser: got %h expected %h", memAddr, dmaWins ? ca : da);
      end
      memReady = 1'b1;
      #1;
      checks++;
      if ({cpuReady, dmaReady} !== {dmaWins, !dmaWins}) begin
        failures++;
        $display("[TB] FAIL contend_lose_ready: got %b%b expected %b%b", cpuReady, dmaReady, dmaWins, !dmaWins);
      end
      tick();
      setCpu('0, 2'b11, 2'b11, '0, 1'b0);
      setDma('0, 2'b11, 2'b11, '0, 1'b0);
      memReady = 1'b0;
      tick();
    end
  endtask

  task automatic test_burst();
    bit          dmaWins;
    logic [27:0] ca0, ca1, ca2, da;
    localReset();
    ca0 = {1'b0, 27'($urandom)};
    ca1 = {1'b0, 27'($urandom)};
    ca2 = {1'b0, 27'($urandom)};
    da  = {1'b1, 27'($urandom)};
    setCpu(ca0, 2'b10, 2'b11, '0, 1'b1);
    setDma(da, 2'b11, 2'b10, 32'hCAFE_0001, 1'b0);
    dmaWins = modelGrant(1'b1, 1'b1);
    tick();
    checks++;
    if ({memAddr, memContinue} !== {(dmaWins ? da : ca0), 1'b1}) begin
      failures++;
      $display("[TB] FAIL burst_first: got %h/%b expected %h/1", memAddr, memContinue, ca0);
    end
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL burst_first_ready: got %b expected 10", {cpuReady, dmaReady});
    end
    tick();
    setCpu(ca1, 2'b10, 2'b11, '0, 1'b1);
    memReady = 1'b0;
    #1;
    checks++;
    if ({memReadN, memContinue} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL burst_lock_gap: got %b expected 111", {memReadN, memContinue});
    end
    tick();
    checks++;
    if ({memAddr, memReadN, memContinue} !== {ca1, 2'b10, 1'b1}) begin
      failures++;
      $display("[TB] FAIL burst_second: got %h/%b/%b expected %h/10/1", memAddr, memReadN, memContinue, ca1);
    end
    tick();
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL burst_second_ready: got %b expected 10", {cpuReady, dmaReady});
    end
    tick();
    setCpu('0, 2'b11, 2'b11, '0, 1'b1);
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL lock_ignores_ready: got %b expected 00", {cpuReady, dmaReady});
    end
    memReady = 1'b0;
    tick();
    checks++;
    if ({memAddr, memReadN, memWriteN, memContinue} !== {ca1, 4'hF, 1'b1}) begin
      failures++;
      $display("[TB] FAIL burst_lock_hold: got %h/%b/%b/%b expected %h/11/11/1",
               memAddr, memReadN, memWriteN, memContinue, ca1);
    end
    setCpu(ca2, 2'b10, 2'b11, '0, 1'b0);
    tick();
    checks++;
    if ({memAddr, memReadN} !== {ca2, 2'b10}) begin
      failures++;
      $display("[TB] FAIL burst_third: got %h/%b expected %h/10", memAddr, memReadN, ca2);
    end
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL burst_third_ready: got %b expected 10", {cpuReady, dmaReady});
    end
    tick();
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b0;
    #1;
    checks++;
    if ({memReadN, memContinue} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL burst_end: got %b expected 110", {memReadN, memContinue});
    end
    dmaWins = modelGrant(1'b0, 1'b1);
    tick();
    checks++;
    if ({memAddr, memWriteN, memDataOut} !== {da, 2'b10, 32'hCAFE_0001}) begin
      failures++;
      $display("[TB] FAIL burst_dma_after: got %h/%b/%h expected %h/10/cafe0001", memAddr, memWriteN, memDataOut, da);
    end
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL burst_dma_ready: got %b expected 01", {cpuReady, dmaReady});
    end
    tick();
    setDma('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    bit          dmaWins;
    logic [27:0] ca, da;
    logic [31:0] r;
    localReset();
    ca = {1'b0, 27'($urandom)};
    da = {1'b1, 27'($urandom)};
    setCpu(ca, 2'b10, 2'b11, '0, 1'b0);
    setDma(da, 2'b11, 2'b10, $urandom, 1'b0);
    for (int g = 0; g < 8; g++) begin
      dmaWins = modelGrant(1'b1, 1'b1);
      tick();
      checks++;
      if (memAddr !== (dmaWins ? da : ca)) begin
        failures++;
        $display("[TB] FAIL fair_grant_%0d: got %h expected %h", g, memAddr, dmaWins ? da : ca);
      end
      r = $urandom;
      memDataIn = r;
      memReady = 1'b1;
      #1;
      checks++;
      if ({cpuReady, dmaReady, rdData} !== {!dmaWins, dmaWins, r}) begin
        failures++;
        $display("[TB] FAIL fair_ready_%0d: got %b%b %h expected %b%b %h",
                 g, cpuReady, dmaReady, rdData, !dmaWins, dmaWins, r);
      end
      tick();
      memReady = 1'b0;
      if (dmaWins) begin
        da = {1'b1, 27'($urandom)};
        setDma(da, 2'b11, 2'b10, $urandom, 1'b0);
      end else begin
        ca = {1'b0, 27'($urandom)};
        setCpu(ca, 2'b10, 2'b11, '0, 1'b0);
      end
    end
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    dmaWins = modelGrant(1'b0, 1'b1);
    tick();
    checks++;
    if (memAddr !== da) begin
      failures++;
      $display("[TB] FAIL fair_drain: got %h expected %h", memAddr, da);
    end
    memReady = 1'b1;
    #1;
    tick();
    setDma('0, 2'b11, 2'b11, '0, 1'b0);
    memReady = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [27:0] ca;
    ca = 28'($urandom);
    setCpu(ca, 2'b10, 2'b11, '0, 1'b1);
    void'(modelGrant(1'b1, 1'b0));
    tick();
    checks++;
    if ({memReadN, memContinue} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL midrst_grant: got %b expected 101", {memReadN, memContinue});
    end
    rstn = 1'b0;
    memReady = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midrst_no_ready: got %b expected 00", {cpuReady, dmaReady});
    end
    tick();
    starveCnt = 0;
    checks++;
    if ({memReadN, memWriteN, memContinue, memAddr} !== {5'b11110, 28'h0}) begin
      failures++;
      $display("[TB] FAIL midrst_state: got %b/%b/%b/%h expected 11/11/0/0", memReadN, memWriteN, memContinue, memAddr);
    end
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    rstn = 1'b1;
    #1;
    checks++;
    if ({cpuReady, dmaReady} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midrst_idle: got %b expected 00", {cpuReady, dmaReady});
    end
    memReady = 1'b0;
    tick();
  endtask

  // Watchdog so a stuck run still terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    rstn = 1'b0;
    memReady = 1'b0;
    memDataIn = '0;
    setCpu('0, 2'b11, 2'b11, '0, 1'b0);
    setDma('0, 2'b11, 2'b11, '0, 1'b0);
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_random_single();
    test_contention();
    test_burst();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tinyqv_data_arbiter.md
# tinyqv_data_arbiter

Two-master arbiter that shares the single downstream data memory port between the tinyQV CPU data interface and a secondary requester (DMA/debug master). It sits between `tinyqv_cpu`'s data port and the memory controller, registers the winning request onto the downstream bus, and routes completion and read data back to the granted master. Sequential bursts marked with `continue` are kept atomic.

## Interface
Parameters:
- `STARVE_LIMIT`, default 3: consecutive CPU wins over a waiting DMA request before the DMA is forced through. Used only with `DATA_ARB_FAIRNESS_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `cpu_addr` in 28: CPU access address.
- `cpu_write_n` in 2: 11 none, 00 byte, 01 half, 10 word.
- `cpu_read_n` in 2: encoding as `cpu_write_n`.
- `cpu_data_out` in 32: CPU write data.
- `cpu_continue` in 1: the next CPU access is sequential; hold the grant.
- `cpu_ready` out 1: CPU transaction complete.
- `dma_addr`, `dma_write_n`, `dma_read_n`, `dma_data_out`, `dma_continue` in 28/2/2/32/1: DMA request, same semantics as the CPU inputs.
- `dma_ready` out 1: DMA transaction complete.
- `rd_data` out 32: `mem_data_in` broadcast to both masters.
- `mem_addr` out 28, `mem_write_n` out 2, `mem_read_n` out 2, `mem_data_out` out 32, `mem_continue` out 1: registered downstream request.
- `mem_ready` in 1: downstream completion.
- `mem_data_in` in 32: downstream read data, valid with `mem_ready`.

## Operation
- A master requests when `read_n != 11` or `write_n != 11`. Only one of the two may be non-11. A master holds all request fields stable until its `ready`.
- States:
  - IDLE: no transaction.
  - BUSY_CPU / BUSY_DMA: a transaction is issued downstream.
  - LOCK_CPU / LOCK_DMA: a burst is held open for the same master.
- IDLE:
  - DMA only requesting: grant DMA.
  - CPU requesting: grant CPU, unless the fairness override applies.
  - On grant, load the master's fields into the `mem_*` registers and go to BUSY_x.
- BUSY_x:
  - `x_ready = mem_ready`. The other master's `ready` is 0.
  - On `mem_ready`, drive `mem_read_n`/`mem_write_n` to 11 on the next edge.
  - If `x_continue` is 1 at `mem_ready`, go to LOCK_x; otherwise go to IDLE.
- LOCK_x:
  - `mem_continue` stays 1. The other master is blocked.
  - When x presents a request, load it and go to BUSY_x.
  - If x deasserts `continue` while not requesting, go to IDLE and drop `mem_continue`.
- `mem_continue` is the registered `x_continue` of the granted master. It is 1 only in BUSY_x or LOCK_x.
- `mem_ready` in IDLE or LOCK_x is ignored. No `ready` is generated.
- `rd_data = mem_data_in` combinationally. A master samples it only on its own `ready`.

## Timing
- Reset values:
  - `mem_read_n = mem_write_n = 11`, `mem_addr = 0`, `mem_data_out = 0`, `mem_continue = 0`.
  - State IDLE; the starvation counter is 0.
  - `cpu_ready = dma_ready = 0`.
- Grant latency: a request sampled in IDLE at edge N appears on `mem_*` after edge N, i.e. 1 cycle.
- Completion: `x_ready` is combinational from `mem_ready` in the same cycle. The downstream request goes idle 1 cycle later.
- Back-to-back without `continue`: 1 IDLE cycle between transactions, during which arbitration reruns.
- Burst (LOCK): the next request of the same master is issued 1 cycle after it is presented. There is no IDLE cycle.
- Simultaneous new requests in IDLE are resolved by priority in one cycle.
- Reset mid-transaction: `rstn = 0` at any edge forces the reset values. An in-flight `ready` is not delivered.

## Configuration
- `DATA_ARB_FAIRNESS_EN` defined:
  - A 2-bit+ counter increments each time the CPU wins while the DMA is requesting. It clears on any DMA grant.
  - When the counter reaches `STARVE_LIMIT`, the DMA wins the next contended arbitration.
  - LOCK_CPU bursts are never broken; the override applies only in IDLE.
- Undefined: the CPU always wins contention, with no counter logic. `STARVE_LIMIT` is unused.

## Test plan
- CPU word read `addr=0x0000100`, `read_n=10`, mem returns `0xDEADBEEF` with `mem_ready` after 3 cycles -> `mem_read_n=10` 1 cycle after the request, `cpu_ready=1` for exactly 1 cycle with `rd_data=0xDEADBEEF`, `dma_ready=0`, `mem_read_n=11` next cycle.
- DMA byte write `addr=0x0000020`, `write_n=00`, data `0x000000A5`, CPU idle -> `mem_write_n=00`, `mem_data_out=0x000000A5`, `dma_ready` on `mem_ready`.
- CPU and DMA request in the same cycle, fairness off -> CPU granted. DMA granted in the IDLE cycle after the CPU `ready`.
- CPU burst of 3 word reads with `cpu_continue=1` on the first two, DMA requesting throughout -> DMA not granted until after the third CPU `ready`. `mem_continue=1` during the burst, 0 after.
- `DATA_ARB_FAIRNESS_EN`, `STARVE_LIMIT=3`, CPU and DMA continuously requesting -> grant order CPU, CPU, CPU, DMA, repeating.
- `rstn` low in the cycle after a grant while BUSY_CPU -> next cycle `mem_read_n=11`, `mem_continue=0`, state IDLE, and no `cpu_ready` even if `mem_ready` pulses.
